// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared opcode constants, control bundle types and decode function
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPV    = 7'b1010111;

    typedef enum logic [1:0] {
        ALUOP_MEM = 2'b00,
        ALUOP_BR  = 2'b01,
        ALUOP_R   = 2'b10,
        ALUOP_I   = 2'b11
    } aluop_e;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       imm_select;
    } ctrl_bundle_t;

    typedef struct packed {
        ctrl_bundle_t ctrl;
        logic         is_vec;
        logic         illegal;
    } decode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_VEC  = 1'b1
    } seq_state_e;

    function automatic decode_t decode_op(input logic [6:0] opcode);
        decode_t d;
        d = '0;
        case (opcode)
            OPC_OPIMM: begin
                d.ctrl.alu_op    = ALUOP_I;
                d.ctrl.alu_src   = 1'b1;
                d.ctrl.reg_write = 1'b1;
            end
            OPC_OP: begin
                d.ctrl.alu_op    = ALUOP_R;
                d.ctrl.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                d.ctrl.alu_op    = ALUOP_BR;
                d.ctrl.alu_src   = 1'b1;
            end
            OPC_LOAD: begin
                d.ctrl.alu_op     = ALUOP_MEM;
                d.ctrl.alu_src    = 1'b1;
                d.ctrl.reg_write  = 1'b1;
                d.ctrl.mem_rd     = 1'b1;
                d.ctrl.mem_to_reg = 1'b1;
            end
            OPC_STORE: begin
                d.ctrl.alu_op     = ALUOP_MEM;
                d.ctrl.alu_src    = 1'b1;
                d.ctrl.mem_wr     = 1'b1;
                d.ctrl.imm_select = 1'b1;
            end
            OPC_OPV: begin
                d.ctrl.alu_op    = ALUOP_MEM;
                d.ctrl.reg_write = 1'b1;
                d.is_vec         = 1'b1;
            end
            default: begin
                // Unknown opcodes take a harmless I-type shape with no side effects
                d.ctrl.alu_op  = ALUOP_I;
                d.ctrl.alu_src = 1'b1;
                d.illegal      = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode to control-bundle decoder
module ctrl_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    output logic [1:0] alu_op_o,
    output logic       alu_src_o,
    output logic       reg_write_o,
    output logic       mem_rd_o,
    output logic       mem_wr_o,
    output logic       mem_to_reg_o,
    output logic       imm_select_o,
    output logic       is_vec_o,
    output logic       illegal_o
);

    decode_t dec;

    assign dec          = decode_op(op_i);
    assign alu_op_o     = dec.ctrl.alu_op;
    assign alu_src_o    = dec.ctrl.alu_src;
    assign reg_write_o  = dec.ctrl.reg_write;
    assign mem_rd_o     = dec.ctrl.mem_rd;
    assign mem_wr_o     = dec.ctrl.mem_wr;
    assign mem_to_reg_o = dec.ctrl.mem_to_reg;
    assign imm_select_o = dec.ctrl.imm_select;
    assign is_vec_o     = dec.is_vec;
    assign illegal_o    = dec.illegal;

endmodule

// File: rtl/vector_seq_control.sv
// rtl/vector_seq_control.sv - registered main control with multi-beat vector sequencer
module vector_seq_control
    import rv_ctrl_pkg::*;
#(
    parameter int VLEN_ELEMS = 4,
    parameter int LANES      = 1,
    localparam int BEATS     = VLEN_ELEMS / LANES,
    localparam int IDX_W     = (VLEN_ELEMS > 1) ? $clog2(VLEN_ELEMS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [6:0]       Op_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic [1:0]       ALUOp_o,
    output logic             ALUSrc_o,
    output logic             RegWrite_o,
    output logic             MemRd_o,
    output logic             MemWr_o,
    output logic             MemToReg_o,
    output logic             immSelect_o,
    output logic             VecOp_o,
    output logic [IDX_W-1:0] VecIdx_o,
    output logic             VecLast_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             illegal_o
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    ctrl_bundle_t dec_ctrl;
    logic         dec_vec;
    logic         dec_illegal;

    seq_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    ctrl_bundle_t     ctrl_q;
    logic             vec_q;
    logic [IDX_W-1:0] idx_q;
    logic             last_q;
    logic             valid_q;
    logic             illegal_q;

    logic [IDX_W-1:0] idx_d;
    logic             beat_last_d;

    ctrl_decode u_decode (
        .op_i         (Op_i),
        .alu_op_o     (dec_ctrl.alu_op),
        .alu_src_o    (dec_ctrl.alu_src),
        .reg_write_o  (dec_ctrl.reg_write),
        .mem_rd_o     (dec_ctrl.mem_rd),
        .mem_wr_o     (dec_ctrl.mem_wr),
        .mem_to_reg_o (dec_ctrl.mem_to_reg),
        .imm_select_o (dec_ctrl.imm_select),
        .is_vec_o     (dec_vec),
        .illegal_o    (dec_illegal)
    );

    // cnt_q is the index of the beat about to be emitted while in VEC
    assign idx_d       = IDX_W'(cnt_q) * IDX_W'(LANES);
    assign beat_last_d = (cnt_q == CNT_W'(BEATS - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            vec_q     <= 1'b0;
            idx_q     <= '0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (!stall_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (valid_i) begin
                        ctrl_q    <= dec_ctrl;
                        vec_q     <= dec_vec;
                        idx_q     <= '0;
                        valid_q   <= 1'b1;
                        illegal_q <= dec_illegal;
                        if (dec_vec && (BEATS > 1)) begin
                            last_q  <= 1'b0;
                            cnt_q   <= CNT_W'(1);
                            state_q <= ST_VEC;
                        end else begin
                            last_q  <= dec_vec;
                            cnt_q   <= '0;
                        end
                    end else begin
                        ctrl_q    <= '0;
                        vec_q     <= 1'b0;
                        idx_q     <= '0;
                        last_q    <= 1'b0;
                        valid_q   <= 1'b0;
                        illegal_q <= 1'b0;
                    end
                end
                ST_VEC: begin
                    // Bundle stays as loaded on accept; only beat position advances
                    valid_q <= 1'b1;
                    idx_q   <= idx_d;
                    last_q  <= beat_last_d;
                    if (beat_last_d) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign ALUOp_o     = ctrl_q.alu_op;
    assign ALUSrc_o    = ctrl_q.alu_src;
    assign RegWrite_o  = ctrl_q.reg_write;
    assign MemRd_o     = ctrl_q.mem_rd;
    assign MemWr_o     = ctrl_q.mem_wr;
    assign MemToReg_o  = ctrl_q.mem_to_reg;
    assign immSelect_o = ctrl_q.imm_select;
    assign VecOp_o     = vec_q;
    assign VecIdx_o    = idx_q;
    assign VecLast_o   = last_q;
    assign valid_o     = valid_q;
    assign busy_o      = (state_q == ST_VEC);
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_vector_seq_control.sv
// tb/tb_vector_seq_control.sv - scoreboard bench for vector_seq_control (LANES=1 and LANES=2)
module tb_vector_seq_control;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OPR    = 7'b0110011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPV    = 7'b1010111;
    localparam logic [6:0] BAD    = 7'b1111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       valid_a, stall_a, flush_a;
    logic [6:0] op_a;
    logic [1:0] aluop_a, idx_a;
    logic       src_a, rw_a, rd_a, wr_a, m2r_a, imm_a, vop_a, last_a, vld_a, busy_a, ill_a;

    logic       valid_b, stall_b, flush_b;
    logic [6:0] op_b;
    logic [1:0] aluop_b, idx_b;
    logic       src_b, rw_b, rd_b, wr_b, m2r_b, imm_b, vop_b, last_b, vld_b, busy_b, ill_b;

    vector_seq_control dut_a (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_a), .Op_i(op_a),
        .stall_i(stall_a), .flush_i(flush_a),
        .ALUOp_o(aluop_a), .ALUSrc_o(src_a), .RegWrite_o(rw_a), .MemRd_o(rd_a),
        .MemWr_o(wr_a), .MemToReg_o(m2r_a), .immSelect_o(imm_a), .VecOp_o(vop_a),
        .VecIdx_o(idx_a), .VecLast_o(last_a), .valid_o(vld_a), .busy_o(busy_a),
        .illegal_o(ill_a)
    );

    vector_seq_control #(.VLEN_ELEMS(4), .LANES(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_b), .Op_i(op_b),
        .stall_i(stall_b), .flush_i(flush_b),
        .ALUOp_o(aluop_b), .ALUSrc_o(src_b), .RegWrite_o(rw_b), .MemRd_o(rd_b),
        .MemWr_o(wr_b), .MemToReg_o(m2r_b), .immSelect_o(imm_b), .VecOp_o(vop_b),
        .VecIdx_o(idx_b), .VecLast_o(last_b), .valid_o(vld_b), .busy_o(busy_b),
        .illegal_o(ill_b)
    );

    // {ALUOp, ALUSrc, RegWrite, MemRd, MemWr, MemToReg, immSel, VecOp, VecIdx, VecLast, busy, illegal}
    logic [13:0] act_a, act_b;
    assign act_a = {aluop_a, src_a, rw_a, rd_a, wr_a, m2r_a, imm_a, vop_a, idx_a, last_a, busy_a, ill_a};
    assign act_b = {aluop_b, src_b, rw_b, rd_b, wr_b, m2r_b, imm_b, vop_b, idx_b, last_b, busy_b, ill_b};

    int tests = 0;
    int fails = 0;

    logic [13:0] q_a[$];
    logic [13:0] q_b[$];
    string       n_a[$];
    string       n_b[$];

    logic stl_a_q = 1'b0;
    logic stl_b_q = 1'b0;

    function automatic logic [13:0] mk(input logic [1:0] alu, input logic [5:0] flags,
                                       input logic vop, input logic [1:0] idx,
                                       input logic last, input logic busy, input logic ill);
        return {alu, flags, vop, idx, last, busy, ill};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_a(input string name, input logic [13:0] e);
        q_a.push_back(e);
        n_a.push_back(name);
    endtask

    task automatic push_b(input string name, input logic [13:0] e);
        q_b.push_back(e);
        n_b.push_back(name);
    endtask

    task automatic issue_a(input logic [6:0] op, input string name, input logic [13:0] e);
        valid_a = 1'b1;
        op_a    = op;
        push_a(name, e);
        step();
    endtask

    // Outputs that did not advance on a stalled edge are not new beats
    always @(posedge clk) begin
        stl_a_q <= stall_a;
        stl_b_q <= stall_b;
    end

    always @(negedge clk) begin
        if (!rst && vld_a && !stl_a_q) begin
            tests++;
            if (q_a.size() == 0) begin
                fails++;
                $display("FAIL a_unexpected: got %0h expected no output", act_a);
            end else begin
                logic [13:0] e;
                string nm;
                e  = q_a.pop_front();
                nm = n_a.pop_front();
                if (act_a !== e) begin
                    fails++;
                    $display("FAIL a_%s: got %b expected %b", nm, act_a, e);
                end
            end
        end
        if (!rst && vld_b && !stl_b_q) begin
            tests++;
            if (q_b.size() == 0) begin
                fails++;
                $display("FAIL b_unexpected: got %0h expected no output", act_b);
            end else begin
                logic [13:0] e;
                string nm;
                e  = q_b.pop_front();
                nm = n_b.pop_front();
                if (act_b !== e) begin
                    fails++;
                    $display("FAIL b_%s: got %b expected %b", nm, act_b, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        valid_a = 1'b1; op_a = LOAD; stall_a = 1'b0; flush_a = 1'b0;
        valid_b = 1'b1; op_b = OPV;  stall_b = 1'b0; flush_b = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_a", {17'd0, act_a, vld_a}, 32'd0);
            check("reset_b", {17'd0, act_b, vld_b}, 32'd0);
        end
        rst = 1'b0;
        valid_b = 1'b0;

        // Scalar sweep, back to back
        issue_a(LOAD,   "load",   mk(2'b00, 6'b111010, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
        issue_a(OPIMM,  "opimm",  mk(2'b11, 6'b110000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
        issue_a(OPR,    "op",     mk(2'b10, 6'b010000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
        issue_a(BRANCH, "branch", mk(2'b01, 6'b100000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
        issue_a(STORE,  "store",  mk(2'b00, 6'b100101, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
        issue_a(BAD,    "illegal", mk(2'b11, 6'b100000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1));
        valid_a = 1'b0;
        step();
        check("bubble_valid", {31'd0, vld_a}, 32'd0);
        check("bubble_flags", {29'd0, rw_a, ill_a, vop_a}, 32'd0);

        // Vector, then ADDI held on the bus until accepted
        push_a("v0", mk(2'b00, 6'b010000, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0));
        push_a("v1", mk(2'b00, 6'b010000, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0));
        push_a("v2", mk(2'b00, 6'b010000, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0));
        push_a("v3", mk(2'b00, 6'b010000, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0));
        push_a("addi_after_vec", mk(2'b11, 6'b110000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
        valid_a = 1'b1; op_a = OPV;
        step();
        op_a = OPIMM;
        repeat (4) step();
        valid_a = 1'b0;
        step();

        // Stall for three cycles while beat 1 is on the outputs
        push_a("s0", mk(2'b00, 6'b010000, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0));
        push_a("s1", mk(2'b00, 6'b010000, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0));
        push_a("s2", mk(2'b00, 6'b010000, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0));
        push_a("s3", mk(2'b00, 6'b010000, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0));
        valid_a = 1'b1; op_a = OPV;
        step();
        valid_a = 1'b0;
        step();
        stall_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", {28'd0, vld_a, busy_a, idx_a}, {28'd0, 1'b1, 1'b1, 2'd1});
        end
        stall_a = 1'b0;
        step();
        step();
        step();

        // Flush while beat 2 is on the outputs, with an OP presented alongside
        push_a("f0", mk(2'b00, 6'b010000, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0));
        push_a("f1", mk(2'b00, 6'b010000, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0));
        push_a("f2", mk(2'b00, 6'b010000, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0));
        valid_a = 1'b1; op_a = OPV;
        step();
        valid_a = 1'b0;
        step();
        step();
        flush_a = 1'b1; valid_a = 1'b1; op_a = OPR;
        step();
        check("flush_out", {27'd0, vld_a, busy_a, vop_a, rw_a, last_a}, 32'd0);
        flush_a = 1'b0;
        issue_a(OPR, "op_after_flush", mk(2'b10, 6'b010000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
        valid_a = 1'b0;
        step();

        // Two-lane instance: two beats at indices 0 and 2
        push_b("l2_b0", mk(2'b00, 6'b010000, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0));
        push_b("l2_b1", mk(2'b00, 6'b010000, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0));
        valid_b = 1'b1; op_b = OPV;
        step();
        valid_b = 1'b0;
        step();
        step();
        step();

        check("a_queue_drained", q_a.size(), 32'd0);
        check("b_queue_drained", q_b.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
